// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] FIN   = 2'd2;

    // Decimal digits needed for a bits-wide unsigned value: ceil(bits * log10(2)).
    function automatic int digits_for(input int bits);
        return (bits * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_dabble_cell.sv
// One BCD digit of the double-dabble chain: add-3 correction then a one-bit shift.
module bcd_dabble_cell
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    input  logic                   carry_in,
    output logic [BCD_DIGIT_W-1:0] digit_out,
    output logic                   carry_out
);

    logic [BCD_DIGIT_W-1:0] adjusted;

    always_comb begin
        adjusted  = (digit_in >= BCD_DIGIT_W'(5)) ? digit_in + BCD_DIGIT_W'(3) : digit_in;
        digit_out = {adjusted[BCD_DIGIT_W-2:0], carry_in};
        carry_out = adjusted[BCD_DIGIT_W-1];
    end

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter, one magnitude bit per clock, with optional
// two's-complement input, overflow detection and significant-digit count.
module bcd_converter
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [BIN_W-1:0]                  binary_input,
    input  logic [$clog2(BIN_W+1)-1:0]        length,
    input  logic                              signed_en,
    output logic                              busy,
    output logic                              done,
    output logic [BCD_DIGIT_W*DIGITS-1:0]     bcd_out,
    output logic                              neg,
    output logic [$clog2(DIGITS+1)-1:0]       ndigits,
    output logic                              overflow
);

    localparam int LEN_W  = $clog2(BIN_W+1);
    localparam int NDIG_W = $clog2(DIGITS+1);
    localparam int BCD_W  = BCD_DIGIT_W * DIGITS;

    logic [1:0]        state;
    logic [LEN_W-1:0]  cnt;
    logic [BIN_W-1:0]  shreg;
    logic [BCD_W-1:0]  acc;
    logic [BCD_W-1:0]  acc_next;
    logic              ovf_acc;
    logic              neg_pend;

    logic [LEN_W-1:0]  eff_len;
    logic [BIN_W-1:0]  len_mask;
    logic [BIN_W-1:0]  masked_in;
    logic [BIN_W-1:0]  magnitude;
    logic [BIN_W-1:0]  aligned;
    logic              sign_bit;
    logic              is_neg;
    logic [NDIG_W-1:0] sig_digits;
    logic [DIGITS:0]   carry;

    // Operand preparation: clamp the length, mask, take magnitude and left-align it.
    always_comb begin
        eff_len  = (length > LEN_W'(BIN_W)) ? LEN_W'(BIN_W) : length;
        len_mask = '0;
        sign_bit = 1'b0;
        for (int i = 0; i < BIN_W; i++) begin
            if (i < int'(eff_len)) len_mask[i] = 1'b1;
            if (int'(eff_len) == i + 1) sign_bit = binary_input[i];
        end
        masked_in = binary_input & len_mask;
        is_neg    = signed_en & sign_bit;
        magnitude = is_neg ? ((~masked_in + BIN_W'(1)) & len_mask) : masked_in;
        aligned   = magnitude << (LEN_W'(BIN_W) - eff_len);
    end

    assign carry[0] = shreg[BIN_W-1];

    for (genvar g = 0; g < DIGITS; g++) begin : g_cell
        bcd_dabble_cell u_cell (
            .digit_in  (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .carry_in  (carry[g]),
            .digit_out (acc_next[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .carry_out (carry[g+1])
        );
    end

    // Highest nonzero digit wins; an all-zero result still reports one digit.
    always_comb begin
        sig_digits = NDIG_W'(1);
        for (int k = 0; k < DIGITS; k++) begin
            if (acc[k*BCD_DIGIT_W +: BCD_DIGIT_W] != '0) sig_digits = NDIG_W'(k + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            acc      <= '0;
            ovf_acc  <= 1'b0;
            neg_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            neg      <= 1'b0;
            ndigits  <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= aligned;
                        acc      <= '0;
                        ovf_acc  <= 1'b0;
                        neg_pend <= is_neg;
                        cnt      <= eff_len;
                        busy     <= 1'b1;
                        state    <= (eff_len == '0) ? FIN : SHIFT;
                    end
                end
                SHIFT: begin
                    acc     <= acc_next;
                    shreg   <= shreg << 1;
                    ovf_acc <= ovf_acc | carry[DIGITS];
                    cnt     <= cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) state <= FIN;
                end
                FIN: begin
                    bcd_out  <= acc;
                    neg      <= neg_pend;
                    overflow <= ovf_acc;
                    ndigits  <= sig_digits;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_converter.sv
// Testbench for bcd_converter: table-driven vectors checked through a result
// scoreboard, plus hand-written handshake and reset sequences.
module tb_bcd_converter;

    typedef struct {
        logic [31:0] bin;
        logic [5:0]  len;
        logic        sgn;
        logic [39:0] bcd;
        logic        neg;
        logic [3:0]  nd;
        logic        ovf;
        int          lat;
    } vec_t;

    typedef struct {
        logic [39:0] bcd;
        logic        neg;
        logic [3:0]  nd;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] binary_input;
    logic [5:0]  length;
    logic        signed_en;
    logic        busy;
    logic        done;
    logic [39:0] bcd_out;
    logic        neg;
    logic [3:0]  ndigits;
    logic        overflow;

    logic        start_s;
    logic [31:0] binary_s;
    logic [5:0]  length_s;
    logic        signed_s;
    logic        busy_s;
    logic        done_s;
    logic [7:0]  bcd_s;
    logic        neg_s;
    logic [1:0]  ndigits_s;
    logic        overflow_s;

    int   n_compared = 0;
    int   n_mismatch = 0;
    int   done_count = 0;
    int   done_count_s = 0;
    logic prev_done = 1'b0;
    exp_t q_main[$];
    exp_t q_small[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    bcd_converter #(.BIN_W(32), .DIGITS(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .binary_input (binary_input),
        .length       (length),
        .signed_en    (signed_en),
        .busy         (busy),
        .done         (done),
        .bcd_out      (bcd_out),
        .neg          (neg),
        .ndigits      (ndigits),
        .overflow     (overflow)
    );

    bcd_converter #(.BIN_W(32), .DIGITS(2)) dut_small (
        .clk          (clk),
        .rst          (rst),
        .start        (start_s),
        .binary_input (binary_s),
        .length       (length_s),
        .signed_en    (signed_s),
        .busy         (busy_s),
        .done         (done_s),
        .bcd_out      (bcd_s),
        .neg          (neg_s),
        .ndigits      (ndigits_s),
        .overflow     (overflow_s)
    );

    function automatic vec_t mk(input logic [31:0] bin, input logic [5:0] len, input logic sgn,
                                input logic [39:0] bcd, input logic ng, input logic [3:0] nd,
                                input logic ovf, input int lat);
        vec_t v;
        v.bin = bin; v.len = len; v.sgn = sgn; v.bcd = bcd;
        v.neg = ng;  v.nd = nd;   v.ovf = ovf; v.lat = lat;
        return v;
    endfunction

    function automatic exp_t mk_exp(input logic [39:0] bcd, input logic ng, input logic [3:0] nd,
                                    input logic ovf);
        exp_t e;
        e.bcd = bcd; e.neg = ng; e.nd = nd; e.ovf = ovf;
        return e;
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Advance one clock, sample after the edge and retire any finished result.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (done) begin
            done_count++;
            check_output("done_single_cycle", 64'(prev_done), 64'(0));
            check_output("sb_main_nonempty", 64'(q_main.size() != 0), 64'(1));
            if (q_main.size() != 0) begin
                e = q_main.pop_front();
                check_output("bcd_out", 64'(bcd_out), 64'(e.bcd));
                check_output("neg", 64'(neg), 64'(e.neg));
                check_output("ndigits", 64'(ndigits), 64'(e.nd));
                check_output("overflow", 64'(overflow), 64'(e.ovf));
            end
        end
        prev_done = done;
        if (done_s) begin
            done_count_s++;
            check_output("sb_small_nonempty", 64'(q_small.size() != 0), 64'(1));
            if (q_small.size() != 0) begin
                e = q_small.pop_front();
                check_output("small_bcd_out", 64'(bcd_s), 64'(e.bcd));
                check_output("small_neg", 64'(neg_s), 64'(e.neg));
                check_output("small_ndigits", 64'(ndigits_s), 64'(e.nd));
                check_output("small_overflow", 64'(overflow_s), 64'(e.ovf));
            end
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        binary_input = v.bin;
        length       = v.len;
        signed_en    = v.sgn;
        start        = 1'b1;
        q_main.push_back(mk_exp(v.bcd, v.neg, v.nd, v.ovf));
    endtask

    task automatic run_vector(input vec_t v);
        int   edges;
        logic got;
        logic busy_ok;
        apply_stimulus(v);
        tick();
        start = 1'b0;
        check_output("busy_after_accept", 64'(busy), 64'(1));
        edges   = 0;
        got     = 1'b0;
        busy_ok = 1'b1;
        while (!got && edges < 100) begin
            tick();
            edges++;
            if (done) got = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        check_output("done_seen", 64'(got), 64'(1));
        if (!got && q_main.size() != 0) void'(q_main.pop_front());
        check_output("latency", 64'(edges), 64'(v.lat));
        check_output("busy_during_conv", 64'(busy_ok), 64'(1));
        check_output("busy_at_done", 64'(busy), 64'(0));
    endtask

    task automatic run_small(input logic [31:0] bin, input logic [5:0] len, input logic sgn,
                             input logic [7:0] bcd, input logic ng, input logic [1:0] nd,
                             input logic ovf);
        int start_cnt;
        int edges;
        binary_s  = bin;
        length_s  = len;
        signed_s  = sgn;
        start_s   = 1'b1;
        q_small.push_back(mk_exp(40'(bcd), ng, 4'(nd), ovf));
        start_cnt = done_count_s;
        tick();
        start_s = 1'b0;
        edges = 0;
        while (done_count_s == start_cnt && edges < 100) begin
            tick();
            edges++;
        end
        check_output("small_done_seen", 64'(done_count_s - start_cnt), 64'(1));
        check_output("small_latency", 64'(edges), 64'(int'(len) + 1));
    endtask

    initial begin
        int first_done;
        int second_done;
        int base;
        rst          = 1'b1;
        start        = 1'b0;
        binary_input = '0;
        length       = '0;
        signed_en    = 1'b0;
        start_s      = 1'b0;
        binary_s     = '0;
        length_s     = '0;
        signed_s     = 1'b0;

        vecs.push_back(mk(32'hFFFFFFFF, 6'd32, 1'b0, 40'h4294967295, 1'b0, 4'd10, 1'b0, 33));
        vecs.push_back(mk(32'h000000FF, 6'd8,  1'b0, 40'h255,        1'b0, 4'd3,  1'b0, 9));
        vecs.push_back(mk(32'h000000FF, 6'd8,  1'b1, 40'h1,          1'b1, 4'd1,  1'b0, 9));
        vecs.push_back(mk(32'h00000080, 6'd8,  1'b1, 40'h128,        1'b1, 4'd3,  1'b0, 9));
        vecs.push_back(mk(32'h00001234, 6'd0,  1'b1, 40'h0,          1'b0, 4'd1,  1'b0, 1));
        vecs.push_back(mk(32'hFFFFFFFF, 6'd40, 1'b0, 40'h4294967295, 1'b0, 4'd10, 1'b0, 33));
        vecs.push_back(mk(32'h00000000, 6'd32, 1'b0, 40'h0,          1'b0, 4'd1,  1'b0, 33));
        vecs.push_back(mk(32'd12345,    6'd32, 1'b0, 40'h12345,      1'b0, 4'd5,  1'b0, 33));
        vecs.push_back(mk(32'h80000000, 6'd32, 1'b1, 40'h2147483648, 1'b1, 4'd10, 1'b0, 33));
        vecs.push_back(mk(32'hFFFFFFFE, 6'd32, 1'b1, 40'h2,          1'b1, 4'd1,  1'b0, 33));
        vecs.push_back(mk(32'h0000001F, 6'd5,  1'b1, 40'h1,          1'b1, 4'd1,  1'b0, 6));
        vecs.push_back(mk(32'hABCD0005, 6'd4,  1'b0, 40'h5,          1'b0, 4'd1,  1'b0, 5));
        vecs.push_back(mk(32'h00000002, 6'd2,  1'b1, 40'h2,          1'b1, 4'd1,  1'b0, 3));
        vecs.push_back(mk(32'h0000007F, 6'd8,  1'b1, 40'h127,        1'b0, 4'd3,  1'b0, 9));
        vecs.push_back(mk(32'h00000001, 6'd1,  1'b1, 40'h1,          1'b1, 4'd1,  1'b0, 2));
        vecs.push_back(mk(32'hFFFFFFFF, 6'd1,  1'b0, 40'h1,          1'b0, 4'd1,  1'b0, 2));
        vecs.push_back(mk(32'h0000FFF0, 6'd16, 1'b1, 40'h16,         1'b1, 4'd2,  1'b0, 17));
        vecs.push_back(mk(32'd1000000000, 6'd32, 1'b0, 40'h1000000000, 1'b0, 4'd10, 1'b0, 33));
        vecs.push_back(mk(32'd999999999,  6'd32, 1'b0, 40'h0999999999, 1'b0, 4'd9,  1'b0, 33));

        repeat (3) tick();
        check_output("rst_busy", 64'(busy), 64'(0));
        check_output("rst_done", 64'(done), 64'(0));
        check_output("rst_bcd_out", 64'(bcd_out), 64'(0));
        check_output("rst_neg", 64'(neg), 64'(0));
        check_output("rst_ndigits", 64'(ndigits), 64'(0));
        check_output("rst_overflow", 64'(overflow), 64'(0));
        check_output("rst_small_ndigits", 64'(ndigits_s), 64'(0));
        rst = 1'b0;
        tick();

        foreach (vecs[i]) run_vector(vecs[i]);

        // Two-digit instance: overflow wraps modulo 100.
        run_small(32'd999, 6'd10, 1'b0, 8'h99, 1'b0, 2'd2, 1'b1);
        run_small(32'd100, 6'd8,  1'b0, 8'h00, 1'b0, 2'd1, 1'b1);
        run_small(32'd99,  6'd8,  1'b0, 8'h99, 1'b0, 2'd2, 1'b0);
        run_small(32'd7,   6'd3,  1'b0, 8'h07, 1'b0, 2'd1, 1'b0);
        run_small(32'h9C,  6'd8,  1'b1, 8'h00, 1'b1, 2'd1, 1'b1);

        // Start held high: re-acceptance only on the done cycle.
        binary_input = 32'd12345;
        length       = 6'd32;
        signed_en    = 1'b0;
        q_main.push_back(mk_exp(40'h12345, 1'b0, 4'd5, 1'b0));
        q_main.push_back(mk_exp(40'h12345, 1'b0, 4'd5, 1'b0));
        start       = 1'b1;
        base        = done_count;
        first_done  = -1;
        second_done = -1;
        for (int i = 0; i < 90; i++) begin
            tick();
            if (i == 49) start = 1'b0;
            if (done) begin
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
            end
        end
        check_output("held_done_count", 64'(done_count - base), 64'(2));
        check_output("held_first_done", 64'(first_done), 64'(33));
        check_output("held_second_done", 64'(second_done), 64'(67));

        // A start pulse while busy is neither accepted nor queued.
        apply_stimulus(mk(32'h000000FF, 6'd8, 1'b0, 40'h255, 1'b0, 4'd3, 1'b0, 9));
        base = done_count;
        tick();
        start        = 1'b0;
        binary_input = 32'h0000000F;
        length       = 6'd4;
        signed_en    = 1'b1;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        check_output("busy_pulse_done_count", 64'(done_count - base), 64'(1));

        // Reset at E10 of a full-width conversion aborts it.
        binary_input = 32'hFFFFFFFF;
        length       = 6'd32;
        signed_en    = 1'b0;
        start        = 1'b1;
        base         = done_count;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        check_output("abort_busy", 64'(busy), 64'(0));
        check_output("abort_done", 64'(done), 64'(0));
        check_output("abort_bcd_out", 64'(bcd_out), 64'(0));
        check_output("abort_neg", 64'(neg), 64'(0));
        check_output("abort_ndigits", 64'(ndigits), 64'(0));
        check_output("abort_overflow", 64'(overflow), 64'(0));
        rst = 1'b0;
        repeat (40) tick();
        check_output("abort_no_done", 64'(done_count - base), 64'(0));

        run_vector(mk(32'd12345, 6'd32, 1'b0, 40'h12345, 1'b0, 4'd5, 1'b0, 33));

        check_output("sb_main_drained", 64'(q_main.size()), 64'(0));
        check_output("sb_small_drained", 64'(q_small.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
